move_arbiter: RTL and testbench
===============================

MOVE_ARBITER -- requirements
Module: move_arbiter

Interface
REQ-001 Parameter LOCK_CYCLES, default 25000000 (1000 under XILINX_SIMULATOR): post-issue lockout length in clocks, legal range at least 2.
REQ-002 Parameter REPEAT_CYCLES, default 12500000 (500 under XILINX_SIMULATOR): hold-to-repeat interval in clocks, legal range at least 2.
REQ-003 Parameter CBITS, default $clog2(max(LOCK_CYCLES,REPEAT_CYCLES)): width of the shared counter.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_btn  input  4  raw pushbuttons, pressed=1; bit0 up, bit1 down, bit2 left, bit3 right.
REQ-007 i_ready  input  1  consumer (maze FSM) accepts the current move.
REQ-008 o_valid  output  1  a move command is presented.
REQ-009 o_dir  output  2  direction index of the presented move (0 up, 1 down, 2 left, 3 right).
REQ-010 o_repeat  output  1  the presented move is an auto-repeat, not a first press.

Function
REQ-011 Each i_btn bit SHALL pass through a 2-flop synchronizer; all logic below uses only the synchronized vector s_btn.
REQ-012 FSM states SHALL be IDLE, ISSUE, LOCK, HOLD; one CBITS-wide counter is shared by LOCK and HOLD.
REQ-013 IDLE: if s_btn != 0, the block SHALL grant one set bit by round-robin starting at pointer rr, latch its index in dir, set o_repeat=0, and go to ISSUE; else it stays in IDLE.
REQ-014 rr SHALL become (granted index + 1) mod 4 on every IDLE grant and SHALL be unchanged by repeats.
REQ-015 ISSUE: o_valid=1 and o_dir=dir SHALL be held stable until a cycle with i_ready=1; on that edge, go to LOCK with counter=0.
REQ-016 o_valid SHALL be 1 only in ISSUE; o_dir and o_repeat are don't-care when o_valid=0 but are registered outputs.
REQ-017 LOCK: the counter SHALL increment each cycle; on the cycle counter==LOCK_CYCLES-1, go to HOLD with counter=0 if s_btn[dir]=1, else go to IDLE.
REQ-018 LOCK SHALL ignore all s_btn changes, including new presses and releases, before its terminal cycle.
REQ-019 HOLD: if s_btn[dir]=0, go to IDLE on the next edge; else the counter SHALL increment, and at counter==REPEAT_CYCLES-1 go to ISSUE with o_repeat=1 and the same dir.
REQ-020 In HOLD, other buttons pressed while dir is held SHALL be ignored until dir is released.
REQ-021 Latency: a press that is stable before edge N with the FSM in IDLE SHALL give o_valid=1 after edge N+3 (2 synchronizer edges, 1 grant edge).
REQ-022 Counters SHALL never wrap: the terminal compare is exact, and the counter is cleared on every state entry.
REQ-023 An i_ready=1 seen outside ISSUE SHALL have no effect.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously force: state IDLE, counter 0, rr 0, dir 0, synchronizer flops 0, o_valid 0, o_dir 0, o_repeat 0.
REQ-025 After rst_n deasserts, the first grant SHALL occur no earlier than 3 edges later; a reset during ISSUE, LOCK or HOLD SHALL abandon the move with no further o_valid.

Verification (LOCK_CYCLES=8, REPEAT_CYCLES=16)
REQ-026 Single tap: i_btn=4'b0100 for 3 clocks, i_ready=1 -> one o_valid pulse, o_dir=2, o_repeat=0, then IDLE after 8 LOCK cycles.
REQ-027 Back-pressure: i_btn=4'b0001, i_ready=0 for 5 clocks then 1 -> o_valid high 6 cycles, o_dir=0 stable throughout, exactly one handshake.
REQ-028 Round-robin: i_btn=4'b1111 held, i_ready=1 with release and re-press between moves -> granted o_dir sequence 0,1,2,3,0.
REQ-029 Auto-repeat: i_btn=4'b1000 held 60 clocks, i_ready=1 -> first move o_repeat=0, then repeats with o_repeat=1, o_dir=3, one move every 25 clocks (1 ISSUE + 8 LOCK + 16 HOLD).
REQ-030 Release in HOLD: hold bit1 until 12 clocks after the handshake, then drop it -> no repeat, FSM in IDLE within 1 clock of the synchronized release.
REQ-031 Async reset: assert rst_n=0 mid-LOCK between clock edges -> o_valid, o_dir, o_repeat read 0 immediately; no o_valid until a new press after release.

Source files
------------

// File: rtl/move_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : move_arbiter
// Purpose  : Turns four raw pushbuttons into handshaked move commands with
//            round-robin grant, post-issue lockout and hold-to-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module move_arbiter #(
`ifdef XILINX_SIMULATOR
    parameter int LOCK_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 500,
`else
    parameter int LOCK_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 12500000,
`endif
    parameter int CBITS = $clog2((LOCK_CYCLES > REPEAT_CYCLES) ? LOCK_CYCLES : REPEAT_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_btn,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [1:0] o_dir,
    output logic       o_repeat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_LOCK  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [CBITS-1:0] c_lock_last = CBITS'(LOCK_CYCLES - 1);
    localparam logic [CBITS-1:0] c_rep_last  = CBITS'(REPEAT_CYCLES - 1);
    localparam logic [CBITS-1:0] c_one       = CBITS'(1);

    state_t           r_state;
    logic [CBITS-1:0] r_cnt;
    logic [1:0]       r_rr;
    logic [1:0]       r_dir;
    logic [3:0]       r_btn_meta;
    logic [3:0]       r_s_btn;

    logic [1:0]       w_grant;
    logic [1:0]       w_idx;
    logic             w_found;

    // Two-flop synchronizer; nothing downstream looks at i_btn directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta <= 4'b0000;
            r_s_btn    <= 4'b0000;
        end else begin
            r_btn_meta <= i_btn;
            r_s_btn    <= r_btn_meta;
        end
    end

    // Round-robin search: first set bit at or after the pointer, wrapping.
    always_comb begin
        w_grant = r_rr;
        w_idx   = r_rr;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_rr + 2'(i);
            if (!w_found && r_s_btn[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rr     <= 2'd0;
            r_dir    <= 2'd0;
            o_valid  <= 1'b0;
            o_dir    <= 2'd0;
            o_repeat <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|r_s_btn) begin
                        r_dir    <= w_grant;
                        o_dir    <= w_grant;
                        o_repeat <= 1'b0;
                        o_valid  <= 1'b1;
                        r_rr     <= w_grant + 2'd1;
                        r_cnt    <= '0;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    // Buttons are only consulted on the terminal cycle.
                    if (r_cnt == c_lock_last) begin
                        r_cnt   <= '0;
                        r_state <= r_s_btn[r_dir] ? S_HOLD : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                S_HOLD: begin
                    if (!r_s_btn[r_dir]) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == c_rep_last) begin
                        r_cnt    <= '0;
                        o_valid  <= 1'b1;
                        o_repeat <= 1'b1;
                        o_dir    <= r_dir;
                        r_state  <= S_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    o_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_move_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_move_arbiter
// Purpose  : Directed self-checking bench for move_arbiter with a move
//            scoreboard checked at every handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] i_btn;
    logic       i_ready;
    logic       o_valid;
    logic [1:0] o_dir;
    logic       o_repeat;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] dir;
        logic       rep;
        int         at;
    } move_t;

    move_t sb[$];
    move_t m;

    move_arbiter #(
        .LOCK_CYCLES  (8),
        .REPEAT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (i_btn),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_dir   (o_dir),
        .o_repeat(o_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor: every accepted move must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            checks++;
            assert ((sb.size() > 0) === 1'b1) else begin
                errors++;
                $error("FAIL unexpected_move: observed dir=%0d rep=%0b, required no move", o_dir, o_repeat);
            end
            if (sb.size() > 0) begin
                m = sb.pop_front();
                checks++;
                assert (o_dir === m.dir) else begin
                    errors++;
                    $error("FAIL hs_dir: observed %0d, required %0d", o_dir, m.dir);
                end
                checks++;
                assert (o_repeat === m.rep) else begin
                    errors++;
                    $error("FAIL hs_repeat: observed %0b, required %0b", o_repeat, m.rep);
                end
                if (m.at >= 0) begin
                    checks++;
                    assert (cyc === m.at) else begin
                        errors++;
                        $error("FAIL hs_cycle: observed %0d, required %0d", cyc, m.at);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] dir, input logic rep, input int at);
        move_t t;
        t.dir = dir;
        t.rep = rep;
        t.at  = at;
        sb.push_back(t);
    endtask

    initial begin
        int base;
        rst_n   = 1'b0;
        i_btn   = 4'b0000;
        i_ready = 1'b0;
        wait_cyc(2);
        chk("rst_valid",  {7'd0, o_valid},  8'd0);
        chk("rst_dir",    {6'd0, o_dir},    8'd0);
        chk("rst_repeat", {7'd0, o_repeat}, 8'd0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Single tap on left, with a later press landing inside the lockout.
        i_btn = 4'b0100; i_ready = 1'b1; push(2'd2, 1'b0, -1);
        wait_cyc(2);
        chk("tap_latency_early", {7'd0, o_valid}, 8'd0);
        wait_cyc(1);
        chk("tap_valid",  {7'd0, o_valid},  8'd1);
        chk("tap_dir",    {6'd0, o_dir},    8'd2);
        chk("tap_repeat", {7'd0, o_repeat}, 8'd0);
        i_btn = 4'b0000;
        wait_cyc(1);
        chk("tap_single_pulse", {7'd0, o_valid}, 8'd0);
        wait_cyc(4);
        i_btn = 4'b0010; push(2'd1, 1'b0, -1);
        wait_cyc(4);
        chk("lock_terminal_quiet", {7'd0, o_valid}, 8'd0);
        wait_cyc(1);
        chk("after_lock_valid", {7'd0, o_valid}, 8'd1);
        chk("after_lock_dir",   {6'd0, o_dir},   8'd1);
        i_btn = 4'b0000;
        wait_cyc(13);
        chk("tap_drained", sb.size() === 0 ? 8'd1 : 8'd0, 8'd1);

        // Back-pressure: consumer stalls five cycles.
        i_ready = 1'b0; i_btn = 4'b0001; push(2'd0, 1'b0, -1);
        wait_cyc(3);
        i_btn = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", {7'd0, o_valid}, 8'd1);
            chk("bp_dir",   {6'd0, o_dir},   8'd0);
            if (i == 5) i_ready = 1'b1;
            wait_cyc(1);
        end
        chk("bp_released", {7'd0, o_valid}, 8'd0);
        wait_cyc(12);
        chk("bp_drained", sb.size() === 0 ? 8'd1 : 8'd0, 8'd1);

        // Round-robin from a freshly reset pointer.
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_btn = 4'b1111; push(2'(k % 4), 1'b0, -1);
            wait_cyc(3);
            chk("rr_valid", {7'd0, o_valid}, 8'd1);
            chk("rr_dir",   {6'd0, o_dir},   8'(k % 4));
            i_btn = 4'b0000;
            wait_cyc(13);
        end
        chk("rr_drained", sb.size() === 0 ? 8'd1 : 8'd0, 8'd1);

        // Auto-repeat on right; a second button joins mid-hold and is ignored.
        base  = cyc;
        i_btn = 4'b1000;
        push(2'd3, 1'b0, base + 3);
        push(2'd3, 1'b1, base + 28);
        push(2'd3, 1'b1, base + 53);
        wait_cyc(3);
        chk("ar_first_repeat", {7'd0, o_repeat}, 8'd0);
        wait_cyc(25);
        chk("ar_second_valid",  {7'd0, o_valid},  8'd1);
        chk("ar_second_repeat", {7'd0, o_repeat}, 8'd1);
        chk("ar_second_dir",    {6'd0, o_dir},    8'd3);
        wait_cyc(2);
        i_btn = 4'b1001;
        wait_cyc(30);
        i_btn = 4'b0000;
        wait_cyc(25);
        chk("ar_drained", sb.size() === 0 ? 8'd1 : 8'd0, 8'd1);

        // Release during hold, with a new button ready to prove return to idle.
        i_btn = 4'b0010; push(2'd1, 1'b0, -1);
        wait_cyc(16);
        i_btn = 4'b0100; push(2'd2, 1'b0, -1);
        wait_cyc(3);
        chk("hold_release_idle", {7'd0, o_valid}, 8'd0);
        wait_cyc(1);
        chk("hold_next_valid", {7'd0, o_valid},  8'd1);
        chk("hold_next_dir",   {6'd0, o_dir},    8'd2);
        chk("hold_next_rep",   {7'd0, o_repeat}, 8'd0);
        i_btn = 4'b0000;
        wait_cyc(40);
        chk("hold_drained", sb.size() === 0 ? 8'd1 : 8'd0, 8'd1);

        // Asynchronous reset in the middle of the lockout.
        i_btn = 4'b1000; push(2'd3, 1'b0, -1);
        wait_cyc(3);
        chk("ar_pre_dir", {6'd0, o_dir}, 8'd3);
        wait_cyc(4);
        rst_n = 1'b0;
        #1;
        chk("async_valid",  {7'd0, o_valid},  8'd0);
        chk("async_dir",    {6'd0, o_dir},    8'd0);
        chk("async_repeat", {7'd0, o_repeat}, 8'd0);
        i_btn = 4'b0000;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(6);
        chk("post_reset_quiet", {7'd0, o_valid}, 8'd0);
        i_btn = 4'b0100; push(2'd2, 1'b0, -1);
        wait_cyc(2);
        chk("post_reset_early", {7'd0, o_valid}, 8'd0);
        wait_cyc(1);
        chk("post_reset_valid", {7'd0, o_valid}, 8'd1);
        chk("post_reset_dir",   {6'd0, o_dir},   8'd2);
        i_btn = 4'b0000;
        wait_cyc(15);
        chk("final_drained", sb.size() === 0 ? 8'd1 : 8'd0, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed timeout, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
